// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential divider.
// States, default operand width and iteration-counter width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

endpackage

// File: rtl/div_seq_if.sv
// Operand/result bundle between the control unit and div_seq.
// DIV_UNSIGNED_EN adds the div_unsigned request qualifier.
interface div_seq_if import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done;
  logic             div_zero;
  logic             busy;
`ifdef DIV_UNSIGNED_EN
  logic             div_unsigned;

  modport master (output start, dividend, divisor, div_unsigned,
                  input  hi, lo, done, div_zero, busy);
  modport slave  (input  start, dividend, divisor, div_unsigned,
                  output hi, lo, done, div_zero, busy);
`else
  modport master (output start, dividend, divisor,
                  input  hi, lo, done, div_zero, busy);
  modport slave  (input  start, dividend, divisor,
                  output hi, lo, done, div_zero, busy);
`endif
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract.
// Purely combinational.
module div_step import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);
  // Keep the bit shifted out of rem: with unsigned operands rem can use the full width.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, q_msb};
  assign diff    = shifted - {1'b0, dvs};
  assign q_bit   = ~diff[WIDTH];
  assign rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_seq.sv
// Multicycle signed divider (MIPS DIV): hi=remainder, lo=quotient; DIV_UNSIGNED_EN adds DIVU.
// Latency: done/hi/lo after WIDTH+1 edges past the accepting edge; divide-by-zero after 1.
// No backpressure: start is honoured only in IDLE, requests while busy are dropped.
module div_seq import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       reset,
  div_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, q, dvs, hi_r, lo_r;
  logic             sq, sr, done_r, div_zero_r;
  logic             uns, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, step_rem;
  logic             step_bit;

`ifdef DIV_UNSIGNED_EN
  assign uns = bus.div_unsigned;
`else
  assign uns = 1'b0;
`endif

  assign a_neg = bus.dividend[WIDTH-1] & ~uns;
  assign b_neg = bus.divisor[WIDTH-1]  & ~uns;
  assign a_mag = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag = b_neg ? -bus.divisor  : bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .q_msb   (q[WIDTH-1]),
    .dvs     (dvs),
    .rem_nxt (step_rem),
    .q_bit   (step_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.divisor == '0) ? ZERO : CALC;
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      ZERO: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      rem        <= '0;
      q          <= '0;
      dvs        <= '0;
      sq         <= 1'b0;
      sr         <= 1'b0;
      hi_r       <= '0;
      lo_r       <= '0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.divisor != '0) begin
            q   <= a_mag;
            dvs <= b_mag;
            rem <= '0;
            cnt <= '0;
            sq  <= a_neg ^ b_neg;
            sr  <= a_neg;
          end
        end
        CALC: begin
          rem <= step_rem;
          q   <= {q[WIDTH-2:0], step_bit};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          lo_r   <= sq ? -q : q;
          hi_r   <= sr ? -rem : rem;
          done_r <= 1'b1;
        end
        ZERO: begin
          done_r     <= 1'b1;
          div_zero_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.done     = done_r;
  assign bus.div_zero = div_zero_r;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_div_seq.sv
// Randomized scoreboard bench for div_seq against an arithmetic DIV/DIVU model.
module tb_div_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          at_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // MIPS DIV/DIVU: quotient truncates toward zero, remainder follows the dividend.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit uns,
                       output logic [31:0] q, output logic [31:0] r);
    int sa, sb_;
    if (uns) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      sa  = a;
      sb_ = b;
      q   = sa / sb_;
      r   = sa % sb_;
    end
  endtask

  // Drive one request at the current negedge; the next posedge accepts it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit uns);
    exp_t e;
    logic [31:0] q, r;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
`ifdef DIV_UNSIGNED_EN
    bus.div_unsigned = uns;
`endif
    if (b == 32'h0) begin
      e.hi = last_hi;
      e.lo = last_lo;
      e.dz = 1'b1;
      e.at_cyc = cyc + 2;
    end else begin
      model(a, b, uns, q, r);
      last_hi = r;
      last_lo = q;
      e.hi = r;
      e.lo = q;
      e.dz = 1'b0;
      e.at_cyc = cyc + 1 + 33;
    end
    sb.push_back(e);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
`ifdef DIV_UNSIGNED_EN
    bus.div_unsigned = $urandom_range(0, 1);
`endif
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", bus.done, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("lo", bus.lo, e.lo);
          chk("hi", bus.hi, e.hi);
          chk("div_zero", bus.div_zero, e.dz);
          chk("busy_at_done", bus.busy, 1'b0);
          chk("latency", cyc, e.at_cyc);
        end
      end else if (bus.div_zero) begin
        chk("div_zero_without_done", bus.div_zero, 1'b0);
      end
    end
  end

  initial begin
    logic [31:0] a, b;
    bit          uns;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef DIV_UNSIGNED_EN
    bus.div_unsigned = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_div_zero", bus.div_zero, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b1;
    @(negedge clk);

    issue(32'd100, 32'd7, 1'b0);
    chk("busy_in_calc", bus.busy, 1'b1);
    drain();
    issue(32'd55, 32'd0, 1'b0);
    drain();
    issue(-32'sd100, 32'd7, 1'b0);
    drain();
    issue(32'd100, -32'sd7, 1'b0);
    drain();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    drain();

    // Abort mid-calculation with reset.
    issue(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_hi", bus.hi, 0);
    chk("abort_lo", bus.lo, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    sb.delete();
    last_hi = '0;
    last_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(32'd9, 32'd3, 1'b0);
    drain();

    // A second start while busy must be dropped.
    issue(32'd100, 32'd7, 1'b0);
    repeat (4) @(negedge clk);
    chk("busy_when_ignored", bus.busy, 1'b1);
    bus.start    = 1'b1;
    bus.dividend = 32'd8;
    bus.divisor  = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

`ifdef DIV_UNSIGNED_EN
    issue(32'hFFFF_FFFE, 32'd2, 1'b1);
    drain();
    issue(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1);
    drain();
`endif

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(1, 31);
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        3:       b = a;
        4:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if (a == 32'h0 && b == 32'h0) b = 32'd3;
`ifdef DIV_UNSIGNED_EN
      uns = $urandom_range(0, 1);
`else
      uns = 1'b0;
`endif
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(a, b, uns);
      drain();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
